// File: rtl/id_control_unit.sv
// rtl/id_control_unit.sv - MIPS32 ID-stage main control decoder and ID/EX control register
module id_control_unit #(
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction_ID,
    input  logic        Valid_ID,
    input  logic        Stall_ID,
    input  logic        Flush_ID,
    output logic        RegDst_EX,
    output logic        ALUSrc_EX,
    output logic        MemtoReg_EX,
    output logic        RegWrite_EX,
    output logic        MemRead_EX,
    output logic        MemWrite_EX,
    output logic        Branch_EX,
    output logic [1:0]  ALUOp_EX,
    output logic [31:0] Sign_Extend_Instruction_EX,
    output logic        Valid_EX,
    output logic        Illegal_Opcode_EX
);

    // Control word order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0]
    logic [8:0]  ctrl_id;
    logic        known_id;
    logic [8:0]  ctrl_ex;
    logic [31:0] imm_ex;
    logic        valid_ex;
    logic        illegal_ex;

    always_comb begin
        ctrl_id  = 9'b0;
        known_id = 1'b1;
        case (Instruction_ID[31:26])
            6'b000000: ctrl_id = 9'b1001000_10;
            6'b100011: ctrl_id = 9'b0111100_00;
            6'b101011: ctrl_id = 9'b0100010_00;
            6'b000100: ctrl_id = 9'b0000001_01;
            6'b001000: begin
                if (ENABLE_ADDI) ctrl_id = 9'b0101000_00;
                else             known_id = 1'b0;
            end
            default:   known_id = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset || Flush_ID) begin
            ctrl_ex    <= 9'b0;
            imm_ex     <= 32'b0;
            valid_ex   <= 1'b0;
            illegal_ex <= 1'b0;
        end else if (Stall_ID) begin
            ctrl_ex    <= ctrl_ex;
            imm_ex     <= imm_ex;
            valid_ex   <= valid_ex;
            illegal_ex <= illegal_ex;
        end else if (!Valid_ID) begin
            ctrl_ex    <= 9'b0;
            imm_ex     <= 32'b0;
            valid_ex   <= 1'b0;
            illegal_ex <= 1'b0;
        end else if (Instruction_ID == 32'h0) begin
            // nop occupies the slot but drives no control
            ctrl_ex    <= 9'b0;
            imm_ex     <= 32'b0;
            valid_ex   <= 1'b1;
            illegal_ex <= 1'b0;
        end else if (!known_id) begin
            ctrl_ex    <= 9'b0;
            imm_ex     <= 32'b0;
            valid_ex   <= 1'b0;
            illegal_ex <= 1'b1;
        end else begin
            ctrl_ex    <= ctrl_id;
            imm_ex     <= {{16{Instruction_ID[15]}}, Instruction_ID[15:0]};
            valid_ex   <= 1'b1;
            illegal_ex <= 1'b0;
        end
    end

    assign RegDst_EX                  = ctrl_ex[8];
    assign ALUSrc_EX                  = ctrl_ex[7];
    assign MemtoReg_EX                = ctrl_ex[6];
    assign RegWrite_EX                = ctrl_ex[5];
    assign MemRead_EX                 = ctrl_ex[4];
    assign MemWrite_EX                = ctrl_ex[3];
    assign Branch_EX                  = ctrl_ex[2];
    assign ALUOp_EX                   = ctrl_ex[1:0];
    assign Sign_Extend_Instruction_EX = imm_ex;
    assign Valid_EX                   = valid_ex;
    assign Illegal_Opcode_EX          = illegal_ex;

endmodule

// File: tb/tb_id_control_unit.sv
// tb/tb_id_control_unit.sv - testbench for id_control_unit (addi enabled and disabled instances)
module tb_id_control_unit;

    typedef struct packed {
        logic        regdst;
        logic        alusrc;
        logic        memtoreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic [1:0]  aluop;
        logic [31:0] imm;
        logic        valid;
        logic        illegal;
    } ex_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instr = 32'h0;
    logic        Valid = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;

    logic        rd1, as1, mr1, rw1, rm1, wm1, br1, v1, il1;
    logic [1:0]  op1;
    logic [31:0] se1;
    logic        rd0, as0, mr0, rw0, rm0, wm0, br0, v0, il0;
    logic [1:0]  op0;
    logic [31:0] se0;

    ex_t obs1, obs0, m1, m0;
    int  errors = 0;
    int  checks = 0;

    always #5 Clk = ~Clk;

    id_control_unit #(.ENABLE_ADDI(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .Instruction_ID(Instr), .Valid_ID(Valid),
        .Stall_ID(Stall), .Flush_ID(Flush),
        .RegDst_EX(rd1), .ALUSrc_EX(as1), .MemtoReg_EX(mr1), .RegWrite_EX(rw1),
        .MemRead_EX(rm1), .MemWrite_EX(wm1), .Branch_EX(br1), .ALUOp_EX(op1),
        .Sign_Extend_Instruction_EX(se1), .Valid_EX(v1), .Illegal_Opcode_EX(il1)
    );

    id_control_unit #(.ENABLE_ADDI(1'b0)) dut_noaddi (
        .Clk(Clk), .Reset(Reset), .Instruction_ID(Instr), .Valid_ID(Valid),
        .Stall_ID(Stall), .Flush_ID(Flush),
        .RegDst_EX(rd0), .ALUSrc_EX(as0), .MemtoReg_EX(mr0), .RegWrite_EX(rw0),
        .MemRead_EX(rm0), .MemWrite_EX(wm0), .Branch_EX(br0), .ALUOp_EX(op0),
        .Sign_Extend_Instruction_EX(se0), .Valid_EX(v0), .Illegal_Opcode_EX(il0)
    );

    assign obs1 = {rd1, as1, mr1, rw1, rm1, wm1, br1, op1, se1, v1, il1};
    assign obs0 = {rd0, as0, mr0, rw0, rm0, wm0, br0, op0, se0, v0, il0};

    // Next EX contents from the current EX contents and this cycle's ID inputs
    function automatic ex_t model(input ex_t prev, input logic rst, input logic fl,
                                  input logic st, input logic v, input logic [31:0] ins,
                                  input bit addi_en);
        ex_t r;
        logic [8:0] c;
        bit ok;
        r = '0;
        if (rst || fl) return r;
        if (st) return prev;
        if (!v) return r;
        if (ins == 32'h0) begin
            r.valid = 1'b1;
            return r;
        end
        ok = 1'b1;
        c  = 9'b0;
        case (ins[31:26])
            6'd0:  c = 9'b100100010;
            6'd35: c = 9'b011110000;
            6'd43: c = 9'b010001000;
            6'd4:  c = 9'b000000101;
            6'd8:  if (addi_en) c = 9'b010100000; else ok = 1'b0;
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            r.illegal = 1'b1;
            return r;
        end
        {r.regdst, r.alusrc, r.memtoreg, r.regwrite, r.memread, r.memwrite, r.branch, r.aluop} = c;
        r.imm   = {{16{ins[15]}}, ins[15:0]};
        r.valid = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        m1 = model(m1, Reset, Flush, Stall, Valid, Instr, 1'b1);
        m0 = model(m0, Reset, Flush, Stall, Valid, Instr, 1'b0);
        #1;
        check({tag, "_a1"}, 64'(obs1), 64'(m1));
        check({tag, "_a0"}, 64'(obs0), 64'(m0));
    endtask

    task automatic drive(input logic rst, input logic fl, input logic st,
                         input logic v, input logic [31:0] ins);
        Reset = rst; Flush = fl; Stall = st; Valid = v; Instr = ins;
    endtask

    logic [5:0]  ops [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd63, 6'd2, 6'd15};
    logic [31:0] rnd;

    initial begin
        m1 = '0;
        m0 = '0;
        // T1: reset for two cycles
        drive(1, 0, 0, 0, 32'h0);
        step("reset0");
        step("reset1");
        check("reset_valid", 64'(v1), 64'd0);
        // T2: add $t0,$t1,$t2
        drive(0, 0, 0, 1, 32'h012A4020);
        step("add");
        check("add_aluop", 64'(op1), 64'd2);
        check("add_funct", 64'(se1[5:0]), 64'h20);
        // T3: lw then beq back to back
        drive(0, 0, 0, 1, 32'h8C28FFFC);
        step("lw");
        check("lw_imm", 64'(se1), 64'hFFFFFFFC);
        drive(0, 0, 0, 1, 32'h1109FFFE);
        step("beq");
        check("beq_aluop", 64'(op1), 64'd1);
        check("beq_imm", 64'(se1), 64'hFFFFFFFE);
        // T4: sw, stall three cycles while ID shows an R-type, then stall+flush
        drive(0, 0, 0, 1, 32'hAD280004);
        step("sw");
        drive(0, 0, 1, 1, 32'h012A4020);
        repeat (3) step("stall");
        check("stall_memwrite", 64'(wm1), 64'd1);
        drive(0, 1, 1, 1, 32'h012A4020);
        step("stall_flush");
        check("flush_valid", 64'(v1), 64'd0);
        // T5: illegal opcode pulse, addi illegal only when disabled
        drive(0, 0, 0, 1, 32'hFC000000);
        step("illegal");
        check("illegal_flag", 64'(il1), 64'd1);
        drive(0, 0, 0, 1, 32'h2108000A);
        step("addi");
        check("illegal_pulse_end", 64'(il1), 64'd0);
        check("addi_disabled", 64'(il0), 64'd1);
        check("addi_enabled_imm", 64'(se1), 64'h0000000A);
        // T6: nop, then reset during a stall
        drive(0, 0, 0, 1, 32'h0);
        step("nop");
        check("nop_valid", 64'(v1), 64'd1);
        drive(0, 0, 0, 1, 32'h8C28FFFC);
        step("lw2");
        drive(0, 0, 1, 1, 32'h8C28FFFC);
        step("stall2");
        drive(1, 0, 1, 1, 32'h8C28FFFC);
        step("reset_in_stall");
        check("reset_in_stall_valid", 64'(v1), 64'd0);
        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            Reset = ($urandom_range(0, 31) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            Stall = ($urandom_range(0, 3) == 0);
            Valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) Instr = 32'h0;
            else Instr = {ops[$urandom_range(0, 7)], rnd[25:0]};
            step("rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
